run_detector: RTL and testbench

Parametrised run-length detector FSM: samples a W-bit symbol every enabled clock and asserts `x` once RUN_LEN consecutive qualifying symbols have been seen. It generalises the fixed 2-bit / length-4 "00-or-11" detector by parametrising symbol width and run length, and adds three qualification modes, a clock enable, a visible run counter and a one-cycle hit pulse. It sits behind an input sampler and feeds control logic that needs a debounced "stable pattern" indication.

---
 rtl/run_det_pkg.sv | 31 +++
 rtl/run_qualify.sv | 39 +++
 rtl/run_detector.sv | 90 +++++++++
 tb/tb_run_detector.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// run_det_pkg: shared definitions for the run-length detector.
//   mode_e      : qualification mode encoding (11 is reserved and behaves as UNIFORM)
//   is_uniform  : returns 1 when the low `width` bits of v are all-zero or all-one
package run_det_pkg;

  typedef enum logic [1:0] {
    MODE_UNIFORM = 2'b00,
    MODE_SAME    = 2'b01,
    MODE_MATCH   = 2'b10
  } mode_e;

  localparam int unsigned MAX_SYM_W = 64;

  // Width is a constant at every call site, so the loop unrolls into a
  // simple AND/NOR reduction over the live bits.
  function automatic logic is_uniform(input logic [MAX_SYM_W-1:0] v,
                                      input int unsigned width);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < MAX_SYM_W; i++) begin
      if (i < width) begin
        all_one  = all_one & v[i];
        all_zero = all_zero & ~v[i];
      end
    end
    return all_one | all_zero;
  endfunction

endpackage

// File: rtl/run_qualify.sv
// run_qualify: combinational classification of one input symbol.
//   w, pattern, last_sym : W-bit symbols
//   mode                 : qualification mode (see run_det_pkg::mode_e)
//   run_cnt              : current run length from the top
//   qual                 : sample extends (or restarts) a run
//   restart              : SAME mode saw a different uniform symbol mid-run
module run_qualify
  import run_det_pkg::*;
#(
  parameter int W     = 2,
  parameter int CNT_W = 3
) (
  input  logic [W-1:0]     w,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     pattern,
  input  logic [W-1:0]     last_sym,
  input  logic [CNT_W-1:0] run_cnt,
  output logic             qual,
  output logic             restart
);

  logic uni;

  assign uni = is_uniform(MAX_SYM_W'(w), W);

  always_comb begin
    qual    = uni;
    restart = 1'b0;
    case (mode)
      MODE_MATCH: qual = (w == pattern);
      MODE_SAME: begin
        qual    = uni;
        restart = uni && (run_cnt != '0) && (w != last_sym);
      end
      default: qual = uni;
    endcase
  end

endmodule

// File: rtl/run_detector.sv
// run_detector: asserts x once RUN_LEN consecutive qualifying symbols are seen.
//   clk, rst  : clock, synchronous active-high reset
//   en        : sample enable; state holds and hit clears when low
//   w         : input symbol (W bits)
//   mode      : 00 UNIFORM, 01 SAME, 10 MATCH, 11 as UNIFORM
//   pattern   : reference symbol for MATCH
//   x         : run complete (run_cnt == RUN_LEN)
//   InIdle    : no run in progress (run_cnt == 0)
//   hit       : one-cycle pulse when run_cnt first reaches RUN_LEN
//   run_cnt   : saturating run length (this register is the FSM state)
//   last_sym  : most recent qualifying symbol
module run_detector
  import run_det_pkg::*;
#(
  parameter int W       = 2,
  parameter int RUN_LEN = 4,
  // Derived from RUN_LEN; not intended to be overridden.
  parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W-1:0]     w,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     pattern,
  output logic             x,
  output logic             InIdle,
  output logic             hit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [W-1:0]     last_sym
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     last_q, last_d;
  logic             hit_q, hit_d;
  logic             qual;
  logic             restart;

  run_qualify #(.W(W), .CNT_W(CNT_W)) u_qualify (
    .w        (w),
    .mode     (mode),
    .pattern  (pattern),
    .last_sym (last_q),
    .run_cnt  (cnt_q),
    .qual     (qual),
    .restart  (restart)
  );

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    hit_d  = 1'b0;
    if (en) begin
      if (!qual) begin
        cnt_d = '0;
      end else begin
        last_d = w;
        if (restart) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Only the step into saturation fires; staying saturated does not.
        hit_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      hit_q  <= hit_d;
    end
  end

  // Moore decode from the registered count only.
  assign x        = (cnt_q == CNT_MAX);
  assign InIdle   = (cnt_q == '0);
  assign hit      = hit_q;
  assign run_cnt  = cnt_q;
  assign last_sym = last_q;

endmodule

// File: tb/tb_run_detector.sv
module tb_run_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: W=2 RUN_LEN=4 ; DUT 1: W=4 RUN_LEN=4 ; DUT 2: W=1 RUN_LEN=1
  logic       a_rst = 0, a_en = 0;
  logic [1:0] a_w = 0, a_mode = 0, a_pat = 0;
  logic       a_x, a_idle, a_hit;
  logic [2:0] a_cnt;
  logic [1:0] a_last;

  logic       b_rst = 0, b_en = 0;
  logic [3:0] b_w = 0, b_pat = 0;
  logic [1:0] b_mode = 0;
  logic       b_x, b_idle, b_hit;
  logic [2:0] b_cnt;
  logic [3:0] b_last;

  logic       c_rst = 0, c_en = 0;
  logic       c_w = 0, c_pat = 0;
  logic [1:0] c_mode = 0;
  logic       c_x, c_idle, c_hit;
  logic [0:0] c_cnt;
  logic       c_last;

  run_detector #(.W(2), .RUN_LEN(4)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .w(a_w), .mode(a_mode), .pattern(a_pat),
    .x(a_x), .InIdle(a_idle), .hit(a_hit), .run_cnt(a_cnt), .last_sym(a_last));
  run_detector #(.W(4), .RUN_LEN(4)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .w(b_w), .mode(b_mode), .pattern(b_pat),
    .x(b_x), .InIdle(b_idle), .hit(b_hit), .run_cnt(b_cnt), .last_sym(b_last));
  run_detector #(.W(1), .RUN_LEN(1)) dut_c (
    .clk(clk), .rst(c_rst), .en(c_en), .w(c_w), .mode(c_mode), .pattern(c_pat),
    .x(c_x), .InIdle(c_idle), .hit(c_hit), .run_cnt(c_cnt), .last_sym(c_last));

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Reference model state per DUT, written from the behavioural rules.
  int widths [3] = '{2, 4, 1};
  int runlen [3] = '{4, 4, 1};
  int m_cnt  [3] = '{0, 0, 0};
  int m_last [3] = '{0, 0, 0};
  int m_hit  [3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  task automatic model(input int d, input int rst, input int en, input int w,
                       input int mode, input int pat);
    int full, uni, q, prev;
    full = (1 << widths[d]) - 1;
    if (rst != 0) begin
      m_cnt[d] = 0; m_last[d] = 0; m_hit[d] = 0;
    end else if (en == 0) begin
      m_hit[d] = 0;
    end else begin
      uni = (w == 0 || w == full) ? 1 : 0;
      q   = (mode == 2) ? ((w == pat) ? 1 : 0) : uni;
      if (q == 0) begin
        m_cnt[d] = 0; m_hit[d] = 0;
      end else begin
        prev = m_cnt[d];
        if (mode == 1 && prev > 0 && w != m_last[d]) m_cnt[d] = 1;
        else m_cnt[d] = (prev + 1 > runlen[d]) ? runlen[d] : prev + 1;
        m_last[d] = w;
        m_hit[d]  = (prev != runlen[d] && m_cnt[d] == runlen[d]) ? 1 : 0;
      end
    end
  endtask

  // One enabled/disabled edge on DUT d; the other DUTs hold.
  task automatic step(input int d, input int rst, input int en, input int w,
                      input int mode, input int pat);
    logic [31:0] o_cnt, o_last, o_x, o_idle, o_hit;
    a_rst = 0; a_en = 0; b_rst = 0; b_en = 0; c_rst = 0; c_en = 0;
    case (d)
      0: begin a_rst = rst[0]; a_en = en[0]; a_w = w[1:0]; a_mode = mode[1:0]; a_pat = pat[1:0]; end
      1: begin b_rst = rst[0]; b_en = en[0]; b_w = w[3:0]; b_mode = mode[1:0]; b_pat = pat[3:0]; end
      default: begin c_rst = rst[0]; c_en = en[0]; c_w = w[0]; c_mode = mode[1:0]; c_pat = pat[0]; end
    endcase
    @(posedge clk);
    #1;
    step_no++;
    model(d, rst, en, w, mode, pat);
    case (d)
      0: begin o_cnt = 32'(a_cnt); o_last = 32'(a_last); o_x = 32'(a_x); o_idle = 32'(a_idle); o_hit = 32'(a_hit); end
      1: begin o_cnt = 32'(b_cnt); o_last = 32'(b_last); o_x = 32'(b_x); o_idle = 32'(b_idle); o_hit = 32'(b_hit); end
      default: begin o_cnt = 32'(c_cnt); o_last = 32'(c_last); o_x = 32'(c_x); o_idle = 32'(c_idle); o_hit = 32'(c_hit); end
    endcase
    $display("step %0d dut=%0d rst=%0d en=%0d w=%0d mode=%0d pat=%0d -> cnt=%0d x=%0d idle=%0d hit=%0d last=%0d",
             step_no, d, rst, en, w, mode, pat, o_cnt, o_x, o_idle, o_hit, o_last);
    chk($sformatf("run_cnt[d%0d]", d), o_cnt, m_cnt[d]);
    chk($sformatf("last_sym[d%0d]", d), o_last, m_last[d]);
    chk($sformatf("x[d%0d]", d), o_x, (m_cnt[d] == runlen[d]) ? 1 : 0);
    chk($sformatf("InIdle[d%0d]", d), o_idle, (m_cnt[d] == 0) ? 1 : 0);
    chk($sformatf("hit[d%0d]", d), o_hit, m_hit[d]);
  endtask

  int r, wv, mv, pv, ev;

  initial begin
    // Reset all three, then non-uniform samples keep DUT 0 idle.
    for (int d = 0; d < 3; d++) step(d, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
    chk("plan_idle_cnt", 32'(a_cnt), 0);

    // UNIFORM basic
    step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 3, 0, 0);
    chk("plan_uniform_hit", 32'(a_hit), 1);
    step(0, 0, 1, 3, 0, 0);
    chk("plan_uniform_sat", 32'(a_cnt), 4);
    step(0, 0, 1, 2, 0, 0);

    // SAME restart
    step(0, 0, 1, 0, 1, 0); step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 3, 1, 0);
    chk("plan_same_restart", 32'(a_cnt), 1);
    step(0, 0, 1, 3, 1, 0); step(0, 0, 1, 3, 1, 0); step(0, 0, 1, 3, 1, 0);
    chk("plan_same_hit", 32'(a_hit), 1);

    // MATCH on the 4-bit instance
    step(1, 0, 1, 10, 2, 10); step(1, 0, 1, 10, 2, 10); step(1, 0, 1, 5, 2, 10);
    step(1, 0, 1, 10, 2, 10); step(1, 0, 1, 10, 2, 10); step(1, 0, 1, 10, 2, 10);
    step(1, 0, 1, 10, 2, 10);
    chk("plan_match_x", 32'(b_x), 1);

    // Enable/reset interaction
    step(0, 0, 1, 2, 0, 0);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 1, 0, 0);
    chk("plan_en_hold", 32'(a_cnt), 3);
    step(0, 0, 1, 0, 0, 0);
    chk("plan_en_x", 32'(a_x), 1);
    step(0, 1, 1, 0, 0, 0);
    chk("plan_rst_prio", 32'(a_cnt), 0);

    // RUN_LEN=1, W=1
    step(2, 0, 1, 1, 0, 0);
    chk("plan_rl1_hit", 32'(c_hit), 1);
    step(2, 0, 1, 0, 0, 0); step(2, 0, 1, 1, 1, 0);

    // Randomized traffic, biased toward qualifying symbols so runs complete.
    for (int i = 0; i < 900; i++) begin
      int d;
      d  = i % 3;
      r  = $urandom_range(99);
      mv = $urandom_range(3);
      ev = ($urandom_range(9) != 0) ? 1 : 0;
      if (d == 0) begin
        pv = $urandom_range(3);
        wv = (r < 75) ? ((r % 2) ? 3 : 0) : $urandom_range(3);
        if (r > 90) wv = pv;
      end else if (d == 1) begin
        pv = ($urandom_range(1) != 0) ? 10 : 15;
        wv = (r < 40) ? pv : (r < 70) ? ((r % 2) ? 15 : 0) : $urandom_range(15);
      end else begin
        pv = $urandom_range(1);
        wv = $urandom_range(1);
      end
      step(d, ($urandom_range(49) == 0) ? 1 : 0, ev, wv, mv, pv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
